multi_unpack: RTL and testbench
===============================

# multi_unpack

Sequential unpacker and serializer for packed value vectors. It accepts one packed word of `VALUE_COUNT` unsigned fields and emits the fields one per beat, field 0 first, over a valid/ready stream. It is the serial counterpart to the parallel packed-vector reduction path in the classifier datapath. It feeds per-value consumers and, optionally, produces the running sum of the fields it emits.

## Interface

Parameters:

- `VALUE_WIDTH`, default 3: width of one field, in bits.
- `VALUE_COUNT`, default 4: number of fields per packed word. Must be 2 or more.
- `SUM_WIDTH`, default 5: width of the `out_sum` output.

Ports:

- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst`, input, 1: reset. Synchronous, active-high.
- `in_values`, input, `VALUE_COUNT*VALUE_WIDTH`: packed word. Field i is bits [i*VALUE_WIDTH +: VALUE_WIDTH].
- `in_valid`, input, 1: `in_values` is valid.
- `in_ready`, output, 1: block can capture a word.
- `out_value`, output, `VALUE_WIDTH`: current field.
- `out_index`, output, `max(1,$clog2(VALUE_COUNT))`: index of the current field.
- `out_last`, output, 1: current field is field `VALUE_COUNT-1`.
- `out_valid`, output, 1: output beat is valid.
- `out_ready`, input, 1: downstream accepts the beat.
- `out_sum`, output, `SUM_WIDTH`: running sum. See Configuration.

## Operation

- The FSM has two states, IDLE and SEND.
- IDLE:
  - `in_ready`=1 and `out_valid`=0.
  - When `in_valid` is high, the word is captured into an internal register, the index is cleared to 0, the accumulator is cleared to 0, and the FSM moves to SEND.
- SEND:
  - `in_ready`=0 and `out_valid`=1.
  - `out_value` is field[index] of the captured word.
  - `out_last` = (index == `VALUE_COUNT-1`).
- A beat transfers on a cycle where `out_valid` and `out_ready` are both high.
  - On a transfer that is not the last beat: index increments and the accumulator adds `out_value`.
  - On a transfer of the last beat: the FSM returns to IDLE.
- While SEND and `out_ready`=0:
  - `out_value`, `out_index`, `out_last` and `out_sum` are held stable.
  - `out_valid` stays high and is never withdrawn.
- `in_values` is sampled only at capture. Later changes to `in_values` do not affect the word being sent.
- The index never wraps past `VALUE_COUNT-1`. The last transfer always forces IDLE.
- `in_valid` is ignored while in SEND. There is no queuing and no loss, because `in_ready`=0 throughout SEND.
- Reset mid-operation: a `rst` high at any edge aborts the current word and forces IDLE. Remaining fields are not emitted.
- Reset values (register state during and after any `rst` edge):
  - `out_valid`=0, `out_value`=0, `out_index`=0, `out_last`=0, `out_sum`=0.
  - `in_ready`=0 while `rst` is high.
  - `in_ready`=1 on the first cycle after `rst` is released.

## Timing

- Latency: a word captured at edge N gives `out_valid`=1 with field 0 in the cycle after edge N.
- Throughput with no backpressure: one word per `VALUE_COUNT+1` cycles (`VALUE_COUNT` beats plus 1 IDLE capture cycle).
- All outputs come from registers or from a mux of registers. `in_ready` has no combinational path from `out_ready`.
- `out_sum` is the accumulator plus `out_value`, truncated to `SUM_WIDTH`. This one adder is the only combinational arithmetic.

## Configuration

- Macro: `MULTI_UNPACK_SUM_EN`.
- When defined:
  - `out_sum` = (sum of fields 0..index of the current word) mod 2^`SUM_WIDTH`. The sum includes the current beat.
  - On the `out_last` beat, `out_sum` is the full word sum.
  - The accumulator is `SUM_WIDTH` bits and wraps on overflow.
- When not defined:
  - The accumulator and adder are not instantiated.
  - `out_sum` is tied to 0.
  - All other behaviour is identical.

## Test plan

Defaults apply unless stated otherwise. Each scenario runs with `MULTI_UNPACK_SUM_EN` defined unless noted.

1. Basic emission.
   - Stimulus: word with fields {4,5,6,7} (field 3..0), `out_ready`=1.
   - Response: beats 7,6,5,4 on consecutive cycles; `out_index` 0,1,2,3; `out_last` only on the 4th beat; `out_sum` 7,13,18,22; `in_ready` back to 1 the cycle after the last beat.
2. Backpressure.
   - Stimulus: {0,7,7,7}, with `out_ready` held low 3 cycles before beat 1.
   - Response: beat 1 holds value 7, index 1, sum 14 stable with `out_valid` high; the sequence completes with final sum 21.
3. Overflow.
   - Stimulus: `SUM_WIDTH`=4, fields {4,5,6,7}.
   - Response: final `out_sum` = 22 mod 16 = 6.
4. Input held and changing.
   - Stimulus: `in_valid` held high continuously, `in_values` changed during SEND.
   - Response: the first word is emitted unchanged; the second word is captured only in the IDLE cycle after the last beat.
5. Reset mid-word.
   - Stimulus: `rst` asserted for 1 cycle after beat 1.
   - Response: next cycle `out_valid`=0 and `out_sum`=0; `in_ready`=1 after release; the next word starts at index 0.
6. Macro undefined.
   - Stimulus: scenario 1 repeated without `MULTI_UNPACK_SUM_EN`.
   - Response: identical beats and flags; `out_sum`=0 on every cycle.

Source files
------------

// File: rtl/multi_unpack.sv
// Serializer for a packed word of VALUE_COUNT fields, field 0 first, over valid/ready.
// Optional running-sum output is enabled by defining MULTI_UNPACK_SUM_EN.
module multi_unpack #(
  parameter int VALUE_WIDTH = 3,
  parameter int VALUE_COUNT = 4,  // must be >= 2, so $clog2 is always >= 1
  parameter int SUM_WIDTH   = 5
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [VALUE_COUNT*VALUE_WIDTH-1:0] in_values,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [VALUE_WIDTH-1:0]             out_value,
  output logic [$clog2(VALUE_COUNT)-1:0]     out_index,
  output logic                               out_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [SUM_WIDTH-1:0]               out_sum
);

  localparam int IDX_W = $clog2(VALUE_COUNT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VALUE_COUNT - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]                         r_state;
  logic [VALUE_COUNT*VALUE_WIDTH-1:0] r_word;
  logic [IDX_W-1:0]                   r_index;
  logic                               r_in_ready;

  logic                   w_send;
  logic                   w_capture;
  logic                   w_xfer;
  logic                   w_last;
  logic [VALUE_WIDTH-1:0] w_field;

  assign w_send    = (r_state == S_SEND);
  // in_ready is its own flop so it never depends on out_ready combinationally.
  assign w_capture = r_in_ready & in_valid;
  assign w_xfer    = w_send & out_ready;
  assign w_last    = (r_index == LAST_IDX);

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_field = '0;
    for (int i = 0; i < VALUE_COUNT; i++) begin
      if (r_index == IDX_W'(i)) w_field = r_word[i*VALUE_WIDTH +: VALUE_WIDTH];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_index    <= '0;
      r_in_ready <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_capture) begin
            r_state    <= S_SEND;
            r_index    <= '0;
            r_in_ready <= 1'b0;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        S_SEND: begin
          if (w_xfer) begin
            if (w_last) begin
              r_state    <= S_IDLE;
              r_index    <= '0;
              r_in_ready <= 1'b1;
            end else begin
              r_index <= r_index + 1'b1;
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_index    <= '0;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the data register has no reset; out_value is gated by state, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (w_capture) r_word <= in_values;
  end

`ifdef MULTI_UNPACK_SUM_EN
  logic [SUM_WIDTH-1:0] r_acc;
  logic [SUM_WIDTH-1:0] w_sum;

  // Accumulator holds the sum of beats already sent; the adder folds in the current beat.
  assign w_sum = r_acc + SUM_WIDTH'(w_field);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (w_capture) begin
      r_acc <= '0;
    end else if (w_xfer && !w_last) begin
      r_acc <= w_sum;
    end
  end

  assign out_sum = w_send ? w_sum : '0;
`else
  assign out_sum = '0;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = w_send;
  assign out_value = w_send ? w_field : '0;
  assign out_index = r_index;
  assign out_last  = w_send & w_last;

endmodule

// File: tb/tb_multi_unpack.sv
// Scoreboard bench for multi_unpack: expected beats are queued at capture and
// compared as the DUT emits them; runs with SUM_WIDTH=4 so the sum wraps.
`timescale 1ns/1ps
module tb_multi_unpack;

  localparam int VW = 3;
  localparam int VC = 4;
  localparam int SW = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [VC*VW-1:0] in_values = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [VW-1:0]    out_value;
  logic [1:0]       out_index;
  logic             out_last;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [SW-1:0]    out_sum;

  multi_unpack #(.VALUE_WIDTH(VW), .VALUE_COUNT(VC), .SUM_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .in_values(in_values), .in_valid(in_valid),
    .in_ready(in_ready), .out_value(out_value), .out_index(out_index),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0] v;
    logic [1:0]    i;
    logic          l;
    logic [SW-1:0] s;
  } beat_t;

  beat_t sb[$];
  int    n_total = 0;
  int    n_bad   = 0;
  bit    bp_rand = 1'b0;

`ifdef MULTI_UNPACK_SUM_EN
  localparam bit SUM_EN = 1'b1;
`else
  localparam bit SUM_EN = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_word(input logic [VC*VW-1:0] w);
    beat_t         b;
    logic [SW-1:0] acc = '0;
    for (int i = 0; i < VC; i++) begin
      b.v = w[i*VW +: VW];
      acc = acc + SW'(b.v);
      b.i = 2'(i);
      b.l = (i == VC - 1);
      b.s = SUM_EN ? acc : '0;
      sb.push_back(b);
    end
  endtask

  // Raises in_valid only on a cycle where in_ready is seen, so every capture is scoreboarded.
  task automatic send_word(input logic [VC*VW-1:0] w, input bit keep_valid);
    int t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        in_valid  = 1'b1;
        in_values = w;
        push_word(w);
        break;
      end
      in_values = VC*VW'($urandom);
      if (++t > 200) begin
        check("capture_timeout", t, 0);
        return;
      end
    end
    @(posedge clk); #1;
    if (!keep_valid) in_valid = 1'b0;
    in_values = VC*VW'($urandom);
    @(negedge clk);
    check("latency_valid", out_valid, 1);
    check("latency_index", out_index, 0);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) check("drain_timeout", sb.size(), 0);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (bp_rand) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: transfers, hold stability and post-last handshake.
  logic          p_hold = 1'b0, p_lastx = 1'b0;
  logic [VW-1:0] p_v;
  logic [1:0]    p_i;
  logic          p_l;
  logic [SW-1:0] p_s;

  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      p_hold  = 1'b0;
      p_lastx = 1'b0;
    end else begin
      if (p_hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_value", out_value, p_v);
        check("hold_index", out_index, p_i);
        check("hold_last",  out_last,  p_l);
        check("hold_sum",   out_sum,   p_s);
      end
      if (p_lastx) begin
        check("post_last_in_ready",  in_ready,  1);
        check("post_last_out_valid", out_valid, 0);
      end
      if (out_valid) begin
        check("in_ready_in_send", in_ready, 0);
        if (sb.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else if (out_ready || !p_hold) begin
          e = sb[0];
          check("beat_value", out_value, e.v);
          check("beat_index", out_index, e.i);
          check("beat_last",  out_last,  e.l);
          check("beat_sum",   out_sum,   e.s);
          if (out_ready) void'(sb.pop_front());
        end
      end
      p_hold  = out_valid && !out_ready;
      p_lastx = out_valid && out_ready && out_last;
      p_v = out_value; p_i = out_index; p_l = out_last; p_s = out_sum;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VC*VW-1:0] w;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready,  0);
    check("rst_out_value", out_value, 0);
    check("rst_out_index", out_index, 0);
    check("rst_out_last",  out_last,  0);
    check("rst_out_sum",   out_sum,   0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("release_in_ready", in_ready, 1);

    // Basic emission, sums wrap at 16: 7,13,2,6
    send_word({3'd4, 3'd5, 3'd6, 3'd7}, 1'b0);
    drain();

    // Backpressure before beat 1
    send_word({3'd0, 3'd7, 3'd7, 3'd7}, 1'b0);
    @(posedge clk); #1 out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // in_valid held high, in_values churned during SEND
    send_word({3'd1, 3'd2, 3'd3, 3'd4}, 1'b1);
    send_word({3'd7, 3'd0, 3'd7, 3'd0}, 1'b0);
    drain();

    // Reset after beat 1
    send_word({3'd3, 3'd3, 3'd3, 3'd3}, 1'b0);
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_sum",   out_sum,   0);
    check("abort_out_index", out_index, 0);
    @(negedge clk);
    check("abort_in_ready", in_ready, 1);
    send_word({3'd6, 3'd5, 3'd4, 3'd2}, 1'b0);
    drain();

    // Random words under random backpressure
    bp_rand = 1'b1;
    for (int k = 0; k < 12; k++) begin
      w = VC*VW'($urandom);
      send_word(w, 1'($urandom_range(0, 1)));
    end
    in_valid = 1'b0;
    drain();
    bp_rand = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    drain();
    check("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
